mem_resp_collect: RTL
=====================

# mem_resp_collect

Parametrised load-response collector for the N-issue memory stage. It latches per-lane load metadata when a batch of loads is accepted, captures each lane's `dresp` data whenever that lane's `data_ok` arrives (in any order, in any cycle), and holds the batch until every pending lane has returned. It then presents aligned, extended and LWL/LWR-merged write-back data with a valid/ready handshake. It sits between the dcache/uncached bus response and the write-back register, and replaces the fixed two-lane, same-cycle extraction path.

## Interface
- `LANES`, default 2: number of issue lanes.
- `DW`, default 32: data width per lane, fixed at 32 in this generation.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with `MEM_RESP_TIMEOUT_EN`.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  LANES  lane carries a load in the offered batch.
- `req_addr_lo`  in  2*LANES  address bits [1:0] per lane.
- `req_msize`  in  2*LANES  0 byte, 1 half, 2 word.
- `req_sext`  in  LANES  sign-extend byte/half.
- `req_memtype`  in  2*LANES  0 normal, 1 LWL, 2 LWR.
- `req_orig`  in  DW*LANES  old rt value for LWL/LWR merge.
- `resp_ok`  in  LANES  per-lane `data_ok`.
- `resp_data`  in  DW*LANES  per-lane response data; lane i occupies [DW*i +: DW].
- `busy`  out  1  collector cannot accept a batch this cycle; upstream stalls.
- `out_valid`  out  1  completed batch presented.
- `out_ready`  in  1  write-back consumes the batch.
- `out_mask`  out  LANES  lanes that carried loads.
- `out_data`  out  DW*LANES  final register write data per lane.
- `out_err`  out  1  batch ended by timeout.

## Operation
- States: IDLE, WAIT, DONE, in a 2-bit encoded register.
- Accept: a batch is accepted when `|req_valid` and either the state is IDLE, or the state is DONE with `out_ready`. On accept:
  - latch metadata into `meta_q`;
  - set `pend_q = req_valid`;
  - set `mask_q = req_valid`;
  - go to WAIT.
- `busy = (state==WAIT) | (state==DONE & ~out_ready)`.
- WAIT: for each lane with `pend_q[i] & resp_ok[i]`, write `raw_q[i] <= resp_data[i]` and clear `pend_q[i]`.
  - `resp_ok` on a non-pending lane is ignored; the first response wins.
  - When the last pending bit clears (including several lanes clearing in the same cycle), go to DONE on that edge.
- `resp_ok` in the accept cycle is ignored. Responses are valid from the following cycle onward.
- DONE:
  - `out_valid=1`, `out_mask=mask_q`;
  - `out_data` is driven combinationally from `raw_q` and `meta_q` through `load_align`;
  - on `out_ready` with no new batch, go to IDLE.
- Extraction per lane, with byte offset o = `addr_lo`:
  - byte: `raw[8o+7:8o]`;
  - half: `raw[16*addr_lo[1]+15 -: 16]`, with `addr_lo[0]` ignored (misalignment is trapped upstream);
  - word: `raw`;
  - zero- or sign-extend to 32 bits per `req_sext`.
- LWL:
  - o=0: `{raw[7:0],orig[23:0]}`;
  - o=1: `{raw[15:0],orig[15:0]}`;
  - o=2: `{raw[23:0],orig[7:0]}`;
  - o=3: `raw`.
- LWR:
  - o=0: `raw`;
  - o=1: `{orig[31:24],raw[31:8]}`;
  - o=2: `{orig[31:16],raw[31:16]}`;
  - o=3: `{orig[31:8],raw[31:24]}`.
- Lanes not in `mask_q` output 0.

## Timing
- Reset values: state IDLE, `pend_q=0`, `mask_q=0`, `raw_q=0`, `meta_q=0`, `out_valid=0`, `out_mask=0`, `out_data=0`, `out_err=0`, `busy=0`.
- Reset mid-batch discards all captured data. Any later `resp_ok` is ignored until the next accept.
- Minimum latency: accept at cycle 0, `resp_ok` at cycle 1, `out_valid` at cycle 2.
- Back-to-back: DONE with `out_ready` and a new batch gives WAIT next cycle, with no IDLE bubble.
- `out_data`, `out_mask` and `out_valid` are stable while `out_valid & ~out_ready`.

## Configuration
- `MEM_RESP_TIMEOUT_EN` defined:
  - an 8-bit-or-wider counter clears on accept and increments in WAIT;
  - when it reaches `TIMEOUT_CYCLES`, the block goes to DONE with `out_err=1`;
  - lanes still pending output 0;
  - `out_err` clears on the handshake.
- Undefined: no counter; `out_err` is tied to 0, and WAIT lasts until every pending lane responds.

## Structure
- Shared package `mem_resp_pkg`: `msize_t`, `memtype_t`, `collect_state_t` enums, `lane_meta_t` struct (`addr_lo`, `msize`, `sext`, `memtype`, `orig`).
- Sub-module `load_align`: purely combinational. One instance per lane, generated over `LANES`, mapping (raw, meta) to final data.

## Test plan
- LANES=2, lane0 LW and lane1 LB with o=3 and sext, data 0x80FF_FF00 on both lanes, same-cycle `resp_ok` at cycle 1 -> `out_valid` at cycle 2, lane0=0x80FF_FF00, lane1=0xFFFF_FF80.
- Lane1 responds at cycle 1 with 0x1111_1111, lane0 at cycle 4 with 0x2222_2222 -> `out_valid` first at cycle 5, both values correct; a duplicate lane1 `resp_ok` at cycle 3 with 0xDEAD_BEEF is ignored.
- LWL o=1, orig 0xAABB_CCDD, raw 0x1234_5678 -> 0x5678_CCDD; LWR o=2, same inputs -> 0xAABB_1234.
- Hold `out_ready=0` for 3 cycles in DONE while offering a batch -> `busy=1`, outputs stable, no accept; on release with the batch still offered -> next cycle is WAIT with the new mask.
- Assert `reset` asynchronously during WAIT -> outputs 0 immediately, state IDLE; a later stale `resp_ok` is ignored.
- With `MEM_RESP_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, lane0 never responds -> DONE with `out_err=1` after 8 WAIT cycles, lane0 data 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the load-response collector: size/merge encodings, FSM states
// and the per-lane metadata latched at batch accept.
package mem_resp_pkg;

   localparam int unsigned LANE_DW = 32;

   typedef enum logic [1:0] {
      MSZ_BYTE = 2'd0,
      MSZ_HALF = 2'd1,
      MSZ_WORD = 2'd2
   } msize_t;

   typedef enum logic [1:0] {
      MT_NORMAL = 2'd0,
      MT_LWL    = 2'd1,
      MT_LWR    = 2'd2
   } memtype_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } collect_state_t;

   typedef struct packed {
      logic [1:0]         addr_lo;
      msize_t             msize;
      logic               sext;
      memtype_t           memtype;
      logic [LANE_DW-1:0] orig;
   } lane_meta_t;

endpackage

// File: rtl/mem_resp_collect_load_align.sv
// Combinational per-lane load formatter: byte/half/word extraction with zero or
// sign extension, and LWL/LWR merge of response data into the old register value.
module load_align
   import mem_resp_pkg::*;
(
   input  logic [31:0] raw_i,
   input  lane_meta_t  meta_i,
   output logic [31:0] data_o
);

   logic [4:0]  sh;
   logic [7:0]  byte_b;
   logic [15:0] half_b;
   logic [31:0] ext_v;
   logic [31:0] keep_lo;

   always_comb begin
      sh = {meta_i.addr_lo, 3'b000};

      case (meta_i.addr_lo)
         2'd0:    byte_b = raw_i[7:0];
         2'd1:    byte_b = raw_i[15:8];
         2'd2:    byte_b = raw_i[23:16];
         default: byte_b = raw_i[31:24];
      endcase
      // addr_lo[0] is ignored for halves; misaligned halves never reach here
      half_b = meta_i.addr_lo[1] ? raw_i[31:16] : raw_i[15:0];

      case (meta_i.msize)
         MSZ_BYTE: ext_v = {{24{meta_i.sext & byte_b[7]}}, byte_b};
         MSZ_HALF: ext_v = {{16{meta_i.sext & half_b[15]}}, half_b};
         default:  ext_v = raw_i;
      endcase

      // LWL keeps the low (3-o) bytes of orig, LWR keeps the high o bytes
      keep_lo = 32'hFFFF_FFFF >> sh;

      case (meta_i.memtype)
         MT_LWL:  data_o = (raw_i << (5'd24 - sh)) | (meta_i.orig & (32'h00FF_FFFF >> sh));
         MT_LWR:  data_o = (raw_i >> sh) | (meta_i.orig & ~keep_lo);
         default: data_o = ext_v;
      endcase
   end

endmodule

// File: rtl/mem_resp_collect.sv
// N-lane load-response collector: latches batch metadata, gathers out-of-order
// per-lane responses and presents formatted write-back data. Optional watchdog
// enabled by defining MEM_RESP_TIMEOUT_EN.
module mem_resp_collect
   import mem_resp_pkg::*;
#(
   parameter int unsigned LANES          = 2,
   parameter int unsigned DW             = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [LANES-1:0]    req_valid,
   input  logic [2*LANES-1:0]  req_addr_lo,
   input  logic [2*LANES-1:0]  req_msize,
   input  logic [LANES-1:0]    req_sext,
   input  logic [2*LANES-1:0]  req_memtype,
   input  logic [DW*LANES-1:0] req_orig,
   input  logic [LANES-1:0]    resp_ok,
   input  logic [DW*LANES-1:0] resp_data,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES-1:0]    out_mask,
   output logic [DW*LANES-1:0] out_data,
   output logic                out_err
);

   collect_state_t               state_q, state_d;
   logic [LANES-1:0]             pend_q, pend_d;
   logic [LANES-1:0]             mask_q, mask_d;
   logic [LANES-1:0][DW-1:0]     raw_q, raw_d;
   lane_meta_t [LANES-1:0]       meta_q, meta_d;
   logic                         accept;
   logic                         timeout;

   assign accept = (|req_valid) &&
                   ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));

`ifdef MEM_RESP_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   assign timeout = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (accept) begin
         cnt_d = '0;
      end else if (state_q == ST_WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (accept || ((state_q == ST_DONE) && out_ready)) begin
         err_d = 1'b0;
      end else if (timeout && (pend_d != '0)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign out_err = err_q;
`else
   assign timeout = 1'b0;
   assign out_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      mask_d  = mask_q;
      raw_d   = raw_q;
      meta_d  = meta_q;

      case (state_q)
         ST_WAIT: begin
            for (int i = 0; i < int'(LANES); i++) begin
               if (pend_q[i] && resp_ok[i]) begin
                  raw_d[i]  = resp_data[DW*i +: DW];
                  pend_d[i] = 1'b0;
               end
            end
            if ((pend_d == '0) || timeout) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
               pend_d  = '0;
            end
         end
         ST_IDLE: ;
         default: state_d = ST_IDLE;
      endcase

      // Accept overrides the DONE->IDLE exit so back-to-back batches skip IDLE
      if (accept) begin
         state_d = ST_WAIT;
         pend_d  = req_valid;
         mask_d  = req_valid;
         for (int i = 0; i < int'(LANES); i++) begin
            meta_d[i].addr_lo = req_addr_lo[2*i +: 2];
            meta_d[i].msize   = msize_t'(req_msize[2*i +: 2]);
            meta_d[i].sext    = req_sext[i];
            meta_d[i].memtype = memtype_t'(req_memtype[2*i +: 2]);
            meta_d[i].orig    = req_orig[DW*i +: DW];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         mask_q  <= '0;
         raw_q   <= '0;
         meta_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         raw_q   <= raw_d;
         meta_q  <= meta_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_WAIT) || ((state_q == ST_DONE) && !out_ready);
   assign out_mask  = out_valid ? mask_q : '0;

   // Lanes still pending in DONE only occur after a watchdog expiry; they read as 0
   for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
      logic [DW-1:0] aligned;
      logic          live;

      load_align u_align (
         .raw_i  (raw_q[g]),
         .meta_i (meta_q[g]),
         .data_o (aligned)
      );

      assign live                 = out_valid && mask_q[g] && !pend_q[g];
      assign out_data[DW*g +: DW] = live ? aligned : '0;
   end

endmodule
